// File: rtl/filter_addr_gen_pkg.sv
// filter_gen_pkg: shared state encoding, index-width helpers and window range check for filter_addr_gen.
package filter_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_w(input int fs);
    return $clog2(fs);
  endfunction
  function automatic int fidx_w(input int nf);
    return $clog2(nf) + 1;
  endfunction
  function automatic logic range_ok(input int base, input int nf, input int stride, input int fs, input int depth);
    return base + (nf - 1) * stride + fs <= depth;
  endfunction
endpackage

// File: rtl/filter_idx_counter.sv
// filter_idx_counter: clearable up-counter with terminal-count flag at MAX (clk, rst active-low sync, clr, inc -> dout, tc).
module filter_idx_counter #(
  parameter int W   = 3,
  parameter int MAX = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] dout,
  output logic         tc
);
  assign tc = dout == W'(MAX);
  always_ff @(posedge clk)
    if (!rst || clr) dout <= '0;
    else if (inc) dout <= dout + 1'b1;
endmodule

// File: rtl/filter_addr_gen.sv
// filter_addr_gen: walks NUM_FILTERS windows of FILTER_SIZE words over a valid/ready read port.
// Ports: clk, rst (sync active-low), start, base_addr, abort, raddr_ready in; raddr_valid, raddr,
// elem_idx, filter_idx, filter_end, run_done, busy, err out. Macro FILTER_ADDR_GEN_WRAP_EN selects a
// circular buffer (addresses modulo BUF_DEPTH); otherwise out-of-range starts are refused and flag err.
module filter_addr_gen
  import filter_gen_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int FILTER_SIZE   = 8,
  parameter int NUM_FILTERS   = 4,
  parameter int FILTER_STRIDE = 8,
  parameter int BUF_DEPTH     = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic                             abort,
  output logic                             raddr_valid,
  input  logic                             raddr_ready,
  output logic [ADDR_W-1:0]                raddr,
  output logic [idx_w(FILTER_SIZE)-1:0]    elem_idx,
  output logic [fidx_w(NUM_FILTERS)-1:0]   filter_idx,
  output logic                             filter_end,
  output logic                             run_done,
  output logic                             busy,
  output logic                             err
);
  localparam int IDX_W  = idx_w(FILTER_SIZE);
  localparam int FIDX_W = fidx_w(NUM_FILTERS);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(BUF_DEPTH);
  state_t state;
  logic [ADDR_W-1:0] head;
  logic hand, ok, go, refuse, e_tc, f_tc;
  function automatic logic [ADDR_W-1:0] red(input logic [ADDR_W:0] v);
`ifdef FILTER_ADDR_GEN_WRAP_EN
    return ADDR_W'(v % DEPTH);
`else
    return v[ADDR_W-1:0];
`endif
  endfunction
`ifdef FILTER_ADDR_GEN_WRAP_EN
  assign ok = 1'b1;
`else
  assign ok = range_ok(int'(base_addr), NUM_FILTERS, FILTER_STRIDE, FILTER_SIZE, BUF_DEPTH);
`endif
  assign raddr_valid = state == RUN;
  assign busy        = state != IDLE;
  // abort squashes the hand-off so neither the counters nor the pulses see it
  assign hand        = raddr_valid & raddr_ready & !abort;
  assign filter_end  = hand & e_tc;
  assign run_done    = filter_end & f_tc;
  assign raddr       = red({1'b0, head} + (ADDR_W+1)'(elem_idx));
  assign go          = state == IDLE & start & !abort & ok;
  assign refuse      = state == IDLE & start & !abort & !ok;
  filter_idx_counter #(.W(IDX_W), .MAX(FILTER_SIZE-1)) u_elem (
    .clk(clk), .rst(rst), .clr(go | abort | filter_end), .inc(hand), .dout(elem_idx), .tc(e_tc)
  );
  filter_idx_counter #(.W(FIDX_W), .MAX(NUM_FILTERS-1)) u_filt (
    .clk(clk), .rst(rst), .clr(go | abort), .inc(filter_end), .dout(filter_idx), .tc(f_tc)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      head  <= '0;
      err   <= 1'b0;
    end else begin
      state <= abort ? IDLE : go ? RUN : run_done ? DONE : state == DONE ? IDLE : state;
      if (go) head <= red({1'b0, base_addr});
      else if (filter_end) head <= red({1'b0, head} + (ADDR_W+1)'(FILTER_STRIDE));
      if (go) err <= 1'b0;
      else if (refuse) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_filter_addr_gen.sv
// tb_filter_addr_gen: directed self-checking bench for filter_addr_gen (default and stride-4 instances).
module tb_filter_addr_gen;
  logic clk = 0, rst = 0, start = 0, s_start = 0, abort = 0, ready = 1;
  logic [15:0] base = '0;
  logic valid, fend, rdone, busy, err;
  logic [15:0] raddr;
  logic [2:0] elem, filt;
  logic s_valid, s_fend, s_rdone, s_busy, s_err;
  logic [15:0] s_raddr;
  logic [2:0] s_elem, s_filt;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  filter_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .abort(abort),
    .raddr_valid(valid), .raddr_ready(ready), .raddr(raddr), .elem_idx(elem),
    .filter_idx(filt), .filter_end(fend), .run_done(rdone), .busy(busy), .err(err)
  );
  filter_addr_gen #(.FILTER_STRIDE(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .base_addr(base), .abort(abort),
    .raddr_valid(s_valid), .raddr_ready(1'b1), .raddr(s_raddr), .elem_idx(s_elem),
    .filter_idx(s_filt), .filter_end(s_fend), .run_done(s_rdone), .busy(s_busy), .err(s_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_word(input int k, input int b);
    #1;
    check($sformatf("valid k=%0d", k), 32'(valid), 1);
    check($sformatf("raddr k=%0d", k), 32'(raddr), 32'((b + k) % 64));
    check($sformatf("elem k=%0d", k), 32'(elem), 32'(k % 8));
    check($sformatf("filt k=%0d", k), 32'(filt), 32'(k / 8));
    check($sformatf("fend k=%0d", k), 32'(fend), 32'(k % 8 == 7));
    check($sformatf("rdone k=%0d", k), 32'(rdone), 32'(k == 31));
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tick(); tick();
    #1;
    check("rst valid", 32'(valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst raddr", 32'(raddr), 0);
    check("rst elem", 32'(elem), 0);
    check("rst filt", 32'(filt), 0);
    check("rst err", 32'(err), 0);
    check("rst fend", 32'(fend), 0);
    check("rst rdone", 32'(rdone), 0);
    rst = 1;
    tick();
    // test 1: full contiguous run from 0
    base = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 32; k++) expect_word(k, 0);
    start = 1;
    #1;
    check("done busy", 32'(busy), 1);
    check("done valid", 32'(valid), 0);
    check("done rdone", 32'(rdone), 0);
    tick();
    start = 0;
    #1;
    check("idle busy", 32'(busy), 0);
    check("idle valid", 32'(valid), 0);
    tick();
    // test 2: overlapping windows with stride 4 from 10
    base = 10; s_start = 1;
    tick();
    s_start = 0;
    for (int k = 0; k < 32; k++) begin
      #1;
      check($sformatf("s raddr k=%0d", k), 32'(s_raddr), 32'(10 + 4 * (k / 8) + k % 8));
      check($sformatf("s fend k=%0d", k), 32'(s_fend), 32'(k % 8 == 7));
      check($sformatf("s rdone k=%0d", k), 32'(s_rdone), 32'(k == 31));
      tick();
    end
    #1;
    check("s done valid", 32'(s_valid), 0);
    tick();
    #1;
    check("s idle busy", 32'(s_busy), 0);
    check("s err", 32'(s_err), 0);
    // test 3: backpressure at raddr 5
    base = 0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 5; k++) expect_word(k, 0);
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp raddr", 32'(raddr), 5);
      check("bp valid", 32'(valid), 1);
      check("bp elem", 32'(elem), 5);
      check("bp fend", 32'(fend), 0);
      tick();
    end
    ready = 1;
    for (int k = 5; k < 15; k++) expect_word(k, 0);
    // test 4: abort on the hand-off of raddr 15
    abort = 1;
    #1;
    check("ab raddr", 32'(raddr), 15);
    check("ab fend", 32'(fend), 0);
    check("ab rdone", 32'(rdone), 0);
    tick();
    abort = 0;
    #1;
    check("ab busy", 32'(busy), 0);
    check("ab valid", 32'(valid), 0);
    check("ab elem", 32'(elem), 0);
    check("ab filt", 32'(filt), 0);
    base = 32; start = 1;
    tick();
    start = 0;
    // test 5: reset at filter_idx 2
    for (int k = 0; k < 16; k++) expect_word(k, 32);
    #1;
    check("pre-rst filt", 32'(filt), 2);
    rst = 0;
    tick();
    #1;
    check("mid-rst busy", 32'(busy), 0);
    check("mid-rst valid", 32'(valid), 0);
    check("mid-rst raddr", 32'(raddr), 0);
    check("mid-rst filt", 32'(filt), 0);
    check("mid-rst elem", 32'(elem), 0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post-rst rdone", 32'(rdone), 0);
      check("post-rst busy", 32'(busy), 0);
    end
    // abort in IDLE outranks start
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    #1;
    check("idle ab busy", 32'(busy), 0);
    tick();
    // test 6: base 40 crosses the buffer end
    base = 40; start = 1;
    tick();
    start = 0;
`ifdef FILTER_ADDR_GEN_WRAP_EN
    for (int k = 0; k < 32; k++) begin
      check($sformatf("wrap err k=%0d", k), 32'(err), 0);
      expect_word(k, 40);
    end
`else
    #1;
    check("rng busy", 32'(busy), 0);
    check("rng err", 32'(err), 1);
    check("rng valid", 32'(valid), 0);
    tick();
    #1;
    check("rng err sticky", 32'(err), 1);
    base = 0; start = 1;
    tick();
    start = 0;
    #1;
    check("rng err clr", 32'(err), 0);
    check("rng restart busy", 32'(busy), 1);
    abort = 1;
    tick();
    abort = 0;
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
